// File: rtl/vpu_pkg.sv
// Shared VPU geometry constants: SRAM bank count/depth and vector datapath width.
package vpu_pkg;

  localparam int unsigned SRAM_BANK_CNT_LG2   = 2;
  localparam int unsigned SRAM_BANK_DEPTH_LG2 = 8;
  localparam int unsigned DIM_SIZE            = 32;

endpackage

// File: rtl/vpu_sram_rd_arbiter.sv
// Round-robin arbiter sharing one SRAM read port among REQ_CNT requesters, with an
// in-order tag FIFO routing responses. Define VPU_SRAM_RD_ARB_PRIO_EN to give requester 0 absolute priority.
module vpu_sram_rd_arbiter
  import vpu_pkg::*;
#(
  parameter int unsigned REQ_CNT     = 3,
  parameter int unsigned OUTST_DEPTH = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [REQ_CNT-1:0]                     req_i,
  input  logic [REQ_CNT*SRAM_BANK_CNT_LG2-1:0]   rid_i,
  input  logic [REQ_CNT*SRAM_BANK_DEPTH_LG2-1:0] addr_i,
  output logic [REQ_CNT-1:0]                     ack_o,
  output logic [REQ_CNT-1:0]                     rvalid_o,
  output logic [DIM_SIZE-1:0]                    rdata_o,
  output logic                                   sram_req_o,
  output logic [SRAM_BANK_CNT_LG2-1:0]           sram_rid_o,
  output logic [SRAM_BANK_DEPTH_LG2-1:0]         sram_addr_o,
  output logic                                   sram_reb_o,
  output logic                                   sram_rlast_o,
  input  logic                                   sram_ack_i,
  input  logic                                   sram_rvalid_i,
  input  logic [DIM_SIZE-1:0]                    sram_rdata_i,
  output logic                                   err_o
);

  localparam int unsigned BW    = SRAM_BANK_CNT_LG2;
  localparam int unsigned DW    = SRAM_BANK_DEPTH_LG2;
  localparam int unsigned IDX_W = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;
  localparam int unsigned AW    = $clog2(OUTST_DEPTH);
  localparam int unsigned PW    = AW + 1;

  typedef enum logic [0:0] {S_IDLE, S_ISSUE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   win_q, last_q, sel_idx, cand;
  logic [BW-1:0]      rid_q;
  logic [DW-1:0]      addr_q;
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [IDX_W-1:0]   tag_mem [OUTST_DEPTH];
  logic [IDX_W-1:0]   tag_head;
  logic               err_q, sel_vld, fifo_full, fifo_empty, grant, push, pop;
  logic [BW-1:0]      rid_arr  [REQ_CNT];
  logic [DW-1:0]      addr_arr [REQ_CNT];

  for (genvar g = 0; g < REQ_CNT; g++) begin : g_unpack
    assign rid_arr[g]  = rid_i[g*BW +: BW];
    assign addr_arr[g] = addr_i[g*DW +: DW];
  end

  // Round-robin search starting just after the last acknowledged winner
  always_comb begin
    sel_idx = '0;
    sel_vld = 1'b0;
    cand    = '0;
    for (int unsigned k = 1; k <= REQ_CNT; k++) begin
      cand = IDX_W'((32'(last_q) + k) % REQ_CNT);
      if (!sel_vld && req_i[cand]) begin
        sel_vld = 1'b1;
        sel_idx = cand;
      end
    end
`ifdef VPU_SRAM_RD_ARB_PRIO_EN
    if (req_i[0]) begin
      sel_vld = 1'b1;
      sel_idx = '0;
    end
`endif
  end

  // Extra MSB on the pointers distinguishes full from empty
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign tag_head   = tag_mem[rd_ptr_q[AW-1:0]];
  assign grant      = (state_q == S_IDLE) && sel_vld && !fifo_full;
  assign push       = (state_q == S_ISSUE) && sram_ack_i;
  assign pop        = sram_rvalid_i && !fifo_empty;

  always_comb begin
    state_d      = state_q;
    sram_req_o   = 1'b0;
    sram_reb_o   = 1'b1;
    sram_rlast_o = 1'b0;
    sram_rid_o   = '0;
    sram_addr_o  = '0;
    ack_o        = '0;
    case (state_q)
      S_IDLE: begin
        if (grant) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        sram_req_o   = 1'b1;
        sram_reb_o   = 1'b0;
        sram_rlast_o = 1'b1;
        sram_rid_o   = rid_q;
        sram_addr_o  = addr_q;
        if (sram_ack_i) begin
          ack_o[win_q] = 1'b1;
          state_d      = S_IDLE;
        end
      end
    endcase
  end

  // Response routing: the oldest outstanding tag owns the returning data
  always_comb begin
    rvalid_o = '0;
    if (pop) rvalid_o[tag_head] = 1'b1;
  end

  assign rdata_o = sram_rdata_i;
  assign err_o   = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      win_q    <= '0;
      rid_q    <= '0;
      addr_q   <= '0;
      last_q   <= IDX_W'(REQ_CNT - 1);
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        win_q  <= sel_idx;
        rid_q  <= rid_arr[sel_idx];
        addr_q <= addr_arr[sel_idx];
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
        last_q   <= win_q;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (sram_rvalid_i && fifo_empty) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr_q[AW-1:0]] <= win_q;
  end

endmodule

// File: tb/tb_vpu_sram_rd_arbiter.sv
// Directed + randomized bench for vpu_sram_rd_arbiter against a queue-based reference model.
module tb_vpu_sram_rd_arbiter;
  import vpu_pkg::*;

  localparam int unsigned N   = 3;
  localparam int unsigned D   = 4;
  localparam int unsigned BW  = SRAM_BANK_CNT_LG2;
  localparam int unsigned AWD = SRAM_BANK_DEPTH_LG2;
  localparam int unsigned DW  = DIM_SIZE;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       req_i;
  logic [N*BW-1:0]    rid_i;
  logic [N*AWD-1:0]   addr_i;
  logic [N-1:0]       ack_o, rvalid_o;
  logic [DW-1:0]      rdata_o;
  logic               sram_req_o, sram_reb_o, sram_rlast_o;
  logic [BW-1:0]      sram_rid_o;
  logic [AWD-1:0]     sram_addr_o;
  logic               sram_ack_i, sram_rvalid_i;
  logic [DW-1:0]      sram_rdata_i;
  logic               err_o;

  vpu_sram_rd_arbiter #(.REQ_CNT(N), .OUTST_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .rid_i(rid_i), .addr_i(addr_i),
    .ack_o(ack_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .sram_req_o(sram_req_o), .sram_rid_o(sram_rid_o), .sram_addr_o(sram_addr_o),
    .sram_reb_o(sram_reb_o), .sram_rlast_o(sram_rlast_o),
    .sram_ack_i(sram_ack_i), .sram_rvalid_i(sram_rvalid_i), .sram_rdata_i(sram_rdata_i),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model: pending-issue flag, last winner, queue of in-flight requester ids
  bit             m_issue;
  int             m_win, m_last;
  logic [BW-1:0]  m_rid;
  logic [AWD-1:0] m_addr;
  int             q[$];
  bit             m_err;

  logic [BW-1:0]  rid_a  [N];
  logic [AWD-1:0] addr_a [N];

  logic [N-1:0]   obs_ack, obs_rv;
  logic           obs_sreq, obs_err;
  logic [BW-1:0]  obs_srid;
  logic [AWD-1:0] obs_saddr;

  int acks[$];
  int rvs[$];
  int ack_cyc[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int pick();
`ifdef VPU_SRAM_RD_ARB_PRIO_EN
    if (req_i[0]) return 0;
`endif
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_last + k) % N;
      if (req_i[c]) return c;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_issue = 1'b0;
    m_last  = N - 1;
    m_win   = 0;
    m_rid   = '0;
    m_addr  = '0;
    q.delete();
    m_err   = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".sreq"},  64'(sram_req_o),   64'd0);
    chk({tag, ".reb"},   64'(sram_reb_o),   64'd1);
    chk({tag, ".rlast"}, 64'(sram_rlast_o), 64'd0);
    chk({tag, ".rid"},   64'(sram_rid_o),   64'd0);
    chk({tag, ".addr"},  64'(sram_addr_o),  64'd0);
    chk({tag, ".ack"},   64'(ack_o),        64'd0);
    chk({tag, ".rv"},    64'(rvalid_o),     64'd0);
    chk({tag, ".err"},   64'(err_o),        64'd0);
  endtask

  // One clock cycle: settle, compare against the model, advance the model at the edge
  task automatic cyc(input string tag);
    logic [N-1:0] ea, ev;
    int sz;
    for (int r = 0; r < N; r++) begin
      rid_i[r*BW +: BW]    = rid_a[r];
      addr_i[r*AWD +: AWD] = addr_a[r];
    end
    #1;
    ea = '0;
    if (m_issue && sram_ack_i) ea[m_win] = 1'b1;
    ev = '0;
    if (sram_rvalid_i && q.size() > 0) ev[q[0]] = 1'b1;
    chk({tag, ".port"}, 64'({sram_req_o, sram_reb_o, sram_rlast_o}), 64'({m_issue, !m_issue, m_issue}));
    chk({tag, ".rid"},  64'(sram_rid_o),  m_issue ? 64'(m_rid)  : 64'd0);
    chk({tag, ".addr"}, 64'(sram_addr_o), m_issue ? 64'(m_addr) : 64'd0);
    chk({tag, ".ack"},  64'(ack_o),       64'(ea));
    chk({tag, ".rv"},   64'(rvalid_o),    64'(ev));
    chk({tag, ".err"},  64'(err_o),       64'(m_err));
    if (ev != '0) chk({tag, ".rdata"}, 64'(rdata_o), 64'(sram_rdata_i));
    obs_ack = ack_o; obs_rv = rvalid_o; obs_sreq = sram_req_o;
    obs_srid = sram_rid_o; obs_saddr = sram_addr_o; obs_err = err_o;
    @(posedge clk);
    sz = q.size();
    if (sram_rvalid_i) begin
      if (sz == 0) m_err = 1'b1;
      else void'(q.pop_front());
    end
    if (m_issue) begin
      if (sram_ack_i) begin
        q.push_back(m_win);
        m_last  = m_win;
        m_issue = 1'b0;
      end
    end else if (req_i != '0 && sz < D) begin
      m_win   = pick();
      m_rid   = rid_a[m_win];
      m_addr  = addr_a[m_win];
      m_issue = 1'b1;
    end
    #1;
  endtask

  task automatic set_in(input logic [N-1:0] rq, input logic ak, input logic rv);
    req_i = rq; sram_ack_i = ak; sram_rvalid_i = rv; sram_rdata_i = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_i = '0; rid_i = '0; addr_i = '0;
    sram_ack_i = 1'b0; sram_rvalid_i = 1'b0; sram_rdata_i = '0;
    for (int r = 0; r < N; r++) begin rid_a[r] = BW'($urandom); addr_a[r] = AWD'($urandom); end
    model_reset();
    #1;
    chk_reset_vals("reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Round robin with all requesting and immediate acks: 0,1,2,0 every 2 cycles
    for (int c = 0; c < 8; c++) begin
      set_in(3'b111, 1'b1, 1'b0);
      cyc("rr");
      if (obs_ack != '0) begin acks.push_back(oh_idx(obs_ack)); ack_cyc.push_back(c); end
    end
    chk("rr.count", 64'(acks.size()), 64'd4);
    if (acks.size() == 4) begin
      chk("rr.g0", 64'(acks[0]), 64'd0);
      chk("rr.g1", 64'(acks[1]), 64'd1);
      chk("rr.g2", 64'(acks[2]), 64'd2);
      chk("rr.g3", 64'(acks[3]), 64'd0);
      for (int i = 1; i < 4; i++) chk("rr.interval", 64'(ack_cyc[i] - ack_cyc[i-1]), 64'd2);
    end
    for (int c = 0; c < 4; c++) begin
      set_in(3'b000, 1'b0, 1'b1);
      cyc("rr.drain");
      if (obs_rv != '0) rvs.push_back(oh_idx(obs_rv));
    end
    chk("rr.rvcount", 64'(rvs.size()), 64'd4);
    if (rvs.size() == 4) begin
      chk("rr.rv0", 64'(rvs[0]), 64'd0);
      chk("rr.rv3", 64'(rvs[3]), 64'd0);
    end

    // Grant held through a delayed ack while req_i changes
    rid_a[1] = 2'd2; addr_a[1] = 8'h1F;
    set_in(3'b010, 1'b0, 1'b0);
    cyc("hold.grant");
    for (int c = 0; c < 3; c++) begin
      set_in((c == 0) ? 3'b010 : 3'b101, 1'b0, 1'b0);
      cyc("hold.wait");
      chk("hold.sreq",  64'(obs_sreq),  64'd1);
      chk("hold.srid",  64'(obs_srid),  64'd2);
      chk("hold.saddr", 64'(obs_saddr), 64'h1F);
      chk("hold.noack", 64'(obs_ack),   64'd0);
    end
    set_in(3'b101, 1'b1, 1'b0);
    cyc("hold.ack");
    chk("hold.ackval", 64'(obs_ack), 64'b010);
    set_in(3'b000, 1'b0, 1'b1);
    cyc("hold.rv");
    chk("hold.rvval", 64'(obs_rv), 64'b010);

    // FIFO full blocks the fifth grant until one response returns
    acks.delete(); rvs.delete();
    for (int c = 0; c < 12; c++) begin
      set_in(3'b111, 1'b1, 1'b0);
      cyc("full");
      if (obs_ack != '0) acks.push_back(oh_idx(obs_ack));
    end
    chk("full.count", 64'(acks.size()), 64'd4);
    chk("full.nosreq", 64'(obs_sreq), 64'd0);
    set_in(3'b111, 1'b1, 1'b1);
    cyc("full.pop");
    if (obs_rv != '0) rvs.push_back(oh_idx(obs_rv));
    for (int c = 0; c < 2; c++) begin
      set_in(3'b111, 1'b1, 1'b0);
      cyc("full.resume");
      if (obs_ack != '0) acks.push_back(oh_idx(obs_ack));
    end
    chk("full.resumed", 64'(acks.size()), 64'd5);
    for (int c = 0; c < 4; c++) begin
      set_in(3'b000, 1'b0, 1'b1);
      cyc("full.drain");
      if (obs_rv != '0) rvs.push_back(oh_idx(obs_rv));
    end
    chk("full.rvcount", 64'(rvs.size()), 64'd5);
    if (acks.size() == 5 && rvs.size() == 5) begin
      int exp_ord[5];
      exp_ord = '{2, 0, 1, 2, 0};
      for (int i = 0; i < 5; i++) begin
        chk("full.ackord", 64'(acks[i]), 64'(exp_ord[i]));
        chk("full.rvord",  64'(rvs[i]),  64'(exp_ord[i]));
      end
    end

    // Randomized traffic; responses only while something is outstanding
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < N; r++) begin rid_a[r] = BW'($urandom); addr_a[r] = AWD'($urandom); end
      set_in(N'($urandom), 1'($urandom_range(0, 1)),
             (q.size() > 0) ? 1'($urandom_range(0, 99) < 40) : 1'b0);
      cyc("rand");
    end
    for (int c = 0; c < 20 && (m_issue || q.size() > 0); c++) begin
      set_in(3'b000, 1'b1, q.size() > 0);
      cyc("rand.drain");
    end
    chk("rand.drained", 64'(q.size()), 64'd0);

    // Response with nothing outstanding sets a sticky error
    set_in(3'b000, 1'b0, 1'b1);
    cyc("err.spur");
    chk("err.norv", 64'(obs_rv), 64'd0);
    for (int c = 0; c < 3; c++) begin
      set_in(3'b000, 1'b0, 1'b0);
      cyc("err.sticky");
      chk("err.val", 64'(obs_err), 64'd1);
    end

    // Asynchronous reset with reads in flight, then a stale response
    do_reset();
    for (int c = 0; c < 4; c++) begin
      set_in(3'b111, 1'b1, 1'b0);
      cyc("rst.fill");
    end
    chk("rst.inflight", 64'(q.size()), 64'd2);
    set_in(3'b111, 1'b1, 1'b1);
    rst = 1'b1;
    #1;
    chk_reset_vals("rst.mid");
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    set_in(3'b000, 1'b0, 1'b1);
    cyc("rst.stale");
    chk("rst.stale_rv", 64'(obs_rv), 64'd0);
    set_in(3'b000, 1'b0, 1'b0);
    cyc("rst.err");
    chk("rst.errset", 64'(obs_err), 64'd1);

`ifdef VPU_SRAM_RD_ARB_PRIO_EN
    do_reset();
    for (int c = 0; c < 12; c++) begin
      set_in(3'b111, 1'b1, q.size() > 0);
      cyc("prio");
      if (obs_ack != '0) chk("prio.win0", 64'(oh_idx(obs_ack)), 64'd0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
